// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: FSM encoding, parameter
// limits and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam int unsigned MIN_DATA_BITS  = 5;
  localparam int unsigned MAX_DATA_BITS  = 9;
  localparam int unsigned MIN_OVERSAMPLE = 4;
  localparam int unsigned MAX_OVERSAMPLE = 64;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic par_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Oversample counter: divides clk into bit periods of Oversample cycles and flags
// the first and last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned Oversample = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_start_o,
  output logic bit_end_o
);

  if (Oversample < MIN_OVERSAMPLE || Oversample > MAX_OVERSAMPLE) begin : g_bad_oversample
    $fatal(1, "uart_baud_cnt: Oversample %0d out of range", Oversample);
  end

  localparam int unsigned CntW = $clog2(Oversample);
  localparam logic [CntW-1:0] CntMax = CntW'(Oversample - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_start_o = en_i & (cnt_q == '0);
  assign bit_end_o   = en_i & (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter on the oversample clock, with a one-entry holding
// register in front of the shift register so frames can run back to back.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk16,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] paral_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_data,
  output logic                 tx_busy,
  output logic                 tx_end,
  output logic                 clk_tx
);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $fatal(1, "uart_tx_param: DATA_BITS %0d out of range", DATA_BITS);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
  end

  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] hold_q, shift_q;
  logic                 hold_full_q, parity_q;
  logic                 start_frame, frame_done, bit_start, bit_end, load;

  assign load = tx_valid & ~hold_full_q;

  uart_baud_cnt #(
    .Oversample (OVERSAMPLE)
  ) u_baud_cnt (
    .clk_i       (clk16),
    .rst_ni      (rst_n),
    .clear_i     (start_frame),
    .en_i        (state_q != StIdle),
    .bit_start_o (bit_start),
    .bit_end_o   (bit_end)
  );

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          state_d     = StStart;
          start_frame = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && bit_cnt_q == DataLast) state_d = (PARITY_EN != 0) ? StParity : StStop;
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end && bit_cnt_q == StopLast) begin
          frame_done = 1'b1;
          // A queued word starts immediately so the line never returns to idle.
          if (hold_full_q) begin
            state_d     = StStart;
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One counter serves both data and stop bits; it restarts on every state change.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (start_frame) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      bit_cnt_d = (state_d != state_q) ? '0 : bit_cnt_q + BitW'(1);
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
    end else begin
      if (load) begin
        hold_q      <= paral_data;
        hold_full_q <= 1'b1;
      end else if (start_frame) begin
        hold_full_q <= 1'b0;
      end
      if (start_frame) begin
        shift_q  <= hold_q;
        parity_q <= par_calc(MAX_DATA_BITS'(hold_q), PARITY_ODD != 0);
      end else if (state_q == StData && bit_end) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  always_comb begin
    serial_data = 1'b1;
    unique case (state_q)
      StStart:  serial_data = 1'b0;
      StData:   serial_data = shift_q[0];
      StParity: serial_data = parity_q;
      default:  serial_data = 1'b1;
    endcase
  end

  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_end   = frame_done;
  assign clk_tx   = bit_start;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations, each with a frame decoder that
// checks every cycle of the line against a word queue.
module tb_uart_tx_param;

  localparam int NI = 4;
  localparam int DB [NI] = '{8, 8, 5, 9};
  localparam int OS [NI] = '{16, 16, 8, 4};
  localparam int PE [NI] = '{0, 1, 0, 1};
  localparam int PO [NI] = '{0, 1, 0, 0};
  localparam int NS [NI] = '{1, 1, 2, 1};

  logic          clk16 = 1'b0;
  logic          rst_n = 1'b0;
  logic [8:0]    pd [NI];
  logic [NI-1:0] vld, rdy, line, busy, endp, ctx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fstart [NI];
  int nframes [NI];
  int nsent [NI];
  bit [8:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk16 = ~clk16;
  always @(posedge clk16) cyc <= cyc + 1;

  uart_tx_param u0 (
    .clk16(clk16), .rst_n(rst_n), .paral_data(pd[0][7:0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .serial_data(line[0]), .tx_busy(busy[0]), .tx_end(endp[0]), .clk_tx(ctx[0])
  );
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk16(clk16), .rst_n(rst_n), .paral_data(pd[1][7:0]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .serial_data(line[1]), .tx_busy(busy[1]), .tx_end(endp[1]), .clk_tx(ctx[1])
  );
  uart_tx_param #(.DATA_BITS(5), .STOP_BITS(2), .OVERSAMPLE(8)) u2 (
    .clk16(clk16), .rst_n(rst_n), .paral_data(pd[2][4:0]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .serial_data(line[2]), .tx_busy(busy[2]), .tx_end(endp[2]), .clk_tx(ctx[2])
  );
  uart_tx_param #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(4)) u3 (
    .clk16(clk16), .rst_n(rst_n), .paral_data(pd[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .serial_data(line[3]), .tx_busy(busy[3]), .tx_end(endp[3]), .clk_tx(ctx[3])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void q_push(input int k, input bit [8:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic bit [8:0] q_pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Line level of bit i of a frame: start, data LSB first, optional parity, stops.
  function automatic bit ref_bit(input int k, input bit [8:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB[k]) return w[i-1];
    if (PE[k] != 0 && i == DB[k] + 1) return bit'(($countones(w) + PO[k]) % 2);
    return 1'b1;
  endfunction

  task automatic check_frame(input int k);
    bit [8:0] w;
    int nb;
    bit ab;
    chk($sformatf("u%0d frame expected", k), q_size(k) > 0, 1);
    w = (q_size(k) > 0) ? q_pop(k) : 9'h0;
    fstart[k] = cyc;
    nb = 1 + DB[k] + PE[k] + NS[k];
    ab = 1'b0;
    for (int b = 0; b < nb && !ab; b++) begin
      bit   exp_b;
      logic lv;
      bit   ebad, sbad, bbad;
      exp_b = ref_bit(k, w, b);
      lv = exp_b;
      ebad = 0; sbad = 0; bbad = 0;
      for (int c = 0; c < OS[k] && !ab; c++) begin
        if (b > 0 || c > 0) @(negedge clk16);
        if (!rst_n) begin
          ab = 1'b1;
        end else begin
          if (lv === exp_b && line[k] !== exp_b) lv = line[k];
          if (endp[k] !== (b == nb - 1 && c == OS[k] - 1)) ebad = 1;
          if (ctx[k] !== (c == 0)) sbad = 1;
          if (busy[k] !== 1'b1) bbad = 1;
        end
      end
      if (!ab) begin
        chk($sformatf("u%0d word %0h bit%0d line", k, w, b), lv, exp_b);
        chk($sformatf("u%0d bit%0d tx_end misplaced", k, b), ebad, 0);
        chk($sformatf("u%0d bit%0d clk_tx misplaced", k, b), sbad, 0);
        chk($sformatf("u%0d bit%0d busy low", k, b), bbad, 0);
      end
    end
    if (!ab) nframes[k]++;
  endtask

  task automatic monitor(input int k);
    forever begin
      @(negedge clk16);
      if (!rst_n || line[k] !== 1'b0) begin
        chk($sformatf("u%0d idle busy", k), busy[k], 0);
        chk($sformatf("u%0d idle tx_end", k), endp[k], 0);
        chk($sformatf("u%0d idle clk_tx", k), ctx[k], 0);
      end else begin
        check_frame(k);
      end
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    initial monitor(g);
  end

  task automatic send(input int k, input bit [8:0] w, output int hs);
    int t;
    t = 0;
    @(negedge clk16);
    vld[k] = 1'b1;
    pd[k] = w;
    while (!rdy[k] && t < 2000) begin
      @(negedge clk16);
      t++;
    end
    chk($sformatf("u%0d send ready", k), rdy[k], 1);
    hs = cyc;
    q_push(k, w & 9'((1 << DB[k]) - 1));
    nsent[k]++;
    @(negedge clk16);
    vld[k] = 1'b0;
  endtask

  task automatic wait_end(input int k, input int budget, output int at);
    int t;
    t = 0;
    at = -1;
    while (t < budget) begin
      @(negedge clk16);
      if (endp[k] === 1'b1) begin
        at = cyc;
        break;
      end
      t++;
    end
    chk($sformatf("u%0d tx_end seen", k), at >= 0, 1);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (t < budget && (q0.size() + q1.size() + q2.size() + q3.size() != 0 || busy != '0)) begin
      @(negedge clk16);
      t++;
    end
    chk("drain complete", busy, 0);
    repeat (2) @(negedge clk16);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, e1, e2, t;
    vld = '0;
    for (int k = 0; k < NI; k++) begin
      pd[k] = '0;
      nframes[k] = 0;
      nsent[k] = 0;
      fstart[k] = 0;
    end
    #3;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d reset line", k), line[k], 1);
      chk($sformatf("u%0d reset ready", k), rdy[k], 1);
      chk($sformatf("u%0d reset busy", k), busy[k], 0);
      chk($sformatf("u%0d reset tx_end", k), endp[k], 0);
      chk($sformatf("u%0d reset clk_tx", k), ctx[k], 0);
    end
    repeat (3) @(negedge clk16);
    rst_n = 1'b1;

    // 8N1 0xA5: handshake-to-start latency and frame length
    send(0, 9'hA5, hs);
    wait_end(0, 400, e1);
    chk("u0 start latency", fstart[0] - hs, 2);
    chk("u0 frame length", e1 - fstart[0] + 1, 160);
    @(negedge clk16);
    chk("u0 busy after end", busy[0], 0);

    // Parity, odd on u1 and even on a 9-bit u3
    send(1, 9'hA5, hs);
    send(3, 9'h0A5, hs);
    wait_end(3, 200, e1);
    chk("u3 frame length", e1 - fstart[3] + 1, 48);
    wait_end(1, 400, e1);
    chk("u1 frame length", e1 - fstart[1] + 1, 176);

    // Back-to-back frames with the second word queued mid-frame
    send(0, 9'h55, hs);
    send(0, 9'h0F, hs);
    repeat (40) @(negedge clk16);
    chk("u0 ready low while holding", rdy[0], 0);
    wait_end(0, 400, e1);
    @(negedge clk16);
    chk("u0 back-to-back busy", busy[0], 1);
    chk("u0 back-to-back start bit", line[0], 0);
    wait_end(0, 400, e2);
    chk("u0 tx_end spacing", e2 - e1, 160);

    // 5 data bits, 2 stop bits, 8x oversample
    send(2, 9'h13, hs);
    wait_end(2, 200, e1);
    chk("u2 frame length", e1 - fstart[2] + 1, 64);
    drain(2000);

    // Reset in the middle of a frame
    send(0, 9'hC3, hs);
    t = 0;
    while (t < 300 && !(busy[0] === 1'b1 && cyc - fstart[0] >= 69)) begin
      @(negedge clk16);
      t++;
    end
    chk("u0 reached mid-frame", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("u0 mid-reset line", line[0], 1);
    chk("u0 mid-reset busy", busy[0], 0);
    chk("u0 mid-reset ready", rdy[0], 1);
    chk("u0 mid-reset tx_end", endp[0], 0);
    repeat (3) @(negedge clk16);
    #2 rst_n = 1'b1;
    @(negedge clk16);
    chk("u0 ready after reset", rdy[0], 1);
    send(0, 9'h3C, hs);
    wait_end(0, 400, e1);
    chk("u0 clean frame after reset", e1 - fstart[0] + 1, 160);

    // tx_valid held high while paral_data changes every cycle
    @(negedge clk16);
    vld[0] = 1'b1;
    for (int i = 0; i < 700; i++) begin
      pd[0] = 9'($urandom);
      if (rdy[0]) begin
        q_push(0, pd[0] & 9'hFF);
        nsent[0]++;
      end
      @(negedge clk16);
    end
    vld[0] = 1'b0;
    drain(3000);

    // Random words to random configurations
    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(0, NI - 1);
      send(k, 9'($urandom), hs);
      repeat ($urandom_range(0, 30)) @(negedge clk16);
    end
    drain(6000);

    for (int k = 0; k < NI; k++) chk($sformatf("u%0d words left", k), q_size(k), 0);
    chk("u0 frames completed", nframes[0], nsent[0] - 1);
    for (int k = 1; k < NI; k++) chk($sformatf("u%0d frames completed", k), nframes[k], nsent[k]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
